// File: rtl/noc_port_arbiter_if.sv
// Handshake bundle between the requesting input ports, the output-port
// arbiter and the downstream link of one NoC switch output.
interface noc_port_arbiter_if #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 3,
  parameter int NumReq    = 3
);
  localparam int W = DataWidth + AddrWidth;

  logic [NumReq*W-1:0] i_req_data;
  logic [NumReq-1:0]   i_req_valid;
  logic [NumReq-1:0]   o_req_ready;
  logic [W-1:0]        o_data;
  logic                o_data_valid;
  logic                i_data_ready;
  logic [NumReq-1:0]   o_grant;

  modport slave (
    input  i_req_data, i_req_valid, i_data_ready,
    output o_req_ready, o_data, o_data_valid, o_grant
  );

  modport master (
    output i_req_data, i_req_valid, i_data_ready,
    input  o_req_ready, o_data, o_data_valid, o_grant
  );
endinterface

// File: rtl/noc_port_arbiter.sv
// Round-robin output-port arbiter: picks one in-window requester per cycle and
// registers the winning flit into a 2-entry output FIFO.
module noc_port_arbiter #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 3,
  parameter int NumReq    = 3,
  parameter int DestMin   = 0,
  parameter int DestMax   = 3
) (
  input  logic               i_sclk,
  input  logic               i_reset,
  noc_port_arbiter_if.slave  bus
);
  localparam int W    = DataWidth + AddrWidth;
  localparam int PtrW = (NumReq > 1) ? $clog2(NumReq) : 1;

  typedef logic [PtrW-1:0] ptr_t;

  logic [NumReq-1:0]   eligible_s;
  logic [2*NumReq-1:0] rotated_s;
  logic                found_s;
  ptr_t                winner_s;
  ptr_t                ptr_next_s;
  logic [W-1:0]        win_flit_s;
  logic                space_s;
  logic                accept_s;
  logic                drain_s;
  logic [NumReq-1:0]   ready_s;

  ptr_t                ptr_r;
  logic [1:0]          count_r;
  logic                head_r;
  logic                tail_r;
  logic [W-1:0]        mem_r [2];
  logic [NumReq-1:0]   grant_r;

  // Signed compare keeps the window test free of unsigned-constant corner cases.
  function automatic logic in_window_f(input logic [AddrWidth-1:0] addr);
    int addr_v;
    addr_v = int'(addr);
    return (addr_v >= DestMin) && (addr_v <= DestMax);
  endfunction

  // Per-requester eligibility: valid and destination inside this port's window.
  always_comb begin
    eligible_s = '0;
    for (int r = 0; r < NumReq; r++) begin
      eligible_s[r] = bus.i_req_valid[r] &&
                      in_window_f(bus.i_req_data[r*W+DataWidth +: AddrWidth]);
    end
  end

  // Round-robin search: rotate eligibility so bit 0 is the requester at ptr.
  always_comb begin
    int sum_v;
    rotated_s = {eligible_s, eligible_s} >> ptr_r;
    found_s   = 1'b0;
    winner_s  = '0;
    sum_v     = 0;
    for (int i = 0; i < NumReq; i++) begin
      if (!found_s && rotated_s[i]) begin
        found_s = 1'b1;
        sum_v   = int'(ptr_r) + i;
        if (sum_v >= NumReq) begin
          sum_v = sum_v - NumReq;
        end else begin
          sum_v = sum_v;
        end
        winner_s = ptr_t'(sum_v);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Winning flit mux and next pointer value.
  always_comb begin
    win_flit_s = '0;
    for (int r = 0; r < NumReq; r++) begin
      if (winner_s == ptr_t'(r)) begin
        win_flit_s = bus.i_req_data[r*W +: W];
      end else begin
        win_flit_s = win_flit_s;
      end
    end
    if (winner_s == ptr_t'(NumReq - 1)) begin
      ptr_next_s = '0;
    end else begin
      ptr_next_s = winner_s + ptr_t'(1);
    end
  end

  // Accept only from registered count; gated while reset is held so no
  // handshake can complete into a buffer that is being cleared.
  always_comb begin
    space_s  = (count_r < 2'd2);
    accept_s = space_s && found_s && i_reset;
    drain_s  = (count_r != 2'd0) && bus.i_data_ready;
    if (accept_s) begin
      ready_s = {{(NumReq-1){1'b0}}, 1'b1} << winner_s;
    end else begin
      ready_s = '0;
    end
  end

  // Pointer, FIFO storage/count and grant history.
  always_ff @(posedge i_sclk or negedge i_reset) begin
    if (!i_reset) begin
      ptr_r    <= '0;
      count_r  <= 2'd0;
      head_r   <= 1'b0;
      tail_r   <= 1'b0;
      mem_r[0] <= '0;
      mem_r[1] <= '0;
      grant_r  <= '0;
    end else begin
      if (accept_s) begin
        mem_r[tail_r] <= win_flit_s;
        tail_r        <= ~tail_r;
        ptr_r         <= ptr_next_s;
      end
      if (drain_s) begin
        head_r <= ~head_r;
      end
      case ({accept_s, drain_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
      grant_r <= ready_s & bus.i_req_valid;
    end
  end

  assign bus.o_req_ready  = ready_s;
  assign bus.o_data       = mem_r[head_r];
  assign bus.o_data_valid = (count_r != 2'd0);
  assign bus.o_grant      = grant_r;

endmodule
